// File: rtl/frame_buffer_swapper.sv
// Double-buffered frame store: pixel writes land in the back buffer, the
// registered read port serves the front buffer, and the buffers swap once
// a finished frame meets a vertical blank (or immediately when SYNC_SWAP=0).
module frame_buffer_swapper #(
  parameter int unsigned BUFFER_WIDTH      = 160,
  parameter int unsigned BUFFER_HEIGHT     = 120,
  parameter int unsigned BUFFER_DATA_WIDTH = 12,
  parameter int unsigned BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH*BUFFER_HEIGHT),
  parameter bit          SYNC_SWAP         = 1'b1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         write_en,
  input  logic [BUFFER_ADDR_WIDTH-1:0] write_addr,
  input  logic [BUFFER_DATA_WIDTH-1:0] write_data,
  input  logic                         frame_done,
  input  logic                         vblank_start,
  input  logic [BUFFER_ADDR_WIDTH-1:0] read_addr,
  output logic [BUFFER_DATA_WIDTH-1:0] read_data,
  output logic                         draw_start,
  output logic                         draw_ack,
  output logic                         buffer_select,
  output logic [7:0]                   frame_count
);

  localparam int unsigned PIXELS   = BUFFER_WIDTH * BUFFER_HEIGHT;
  localparam logic [63:0] PIXELS_W = 64'(BUFFER_WIDTH) * 64'(BUFFER_HEIGHT);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_WAIT_FRAME,
    ST_WAIT_VBLANK,
    ST_SWAP
  } state_t;

  state_t                       r_state;
  logic                         r_draw_start;
  logic                         r_draw_ack;
  logic                         r_buf_sel;
  logic [7:0]                   r_frame_count;
  logic [BUFFER_DATA_WIDTH-1:0] r_read_data;

  logic [BUFFER_DATA_WIDTH-1:0] r_mem0 [PIXELS];
  logic [BUFFER_DATA_WIDTH-1:0] r_mem1 [PIXELS];

  logic w_wr_in_range;
  logic w_rd_in_range;
  logic w_wr_en0;
  logic w_wr_en1;

  // Range checks at 64-bit width so no product of the dimensions truncates.
  assign w_wr_in_range = (64'(write_addr) < PIXELS_W);
  assign w_rd_in_range = (64'(read_addr) < PIXELS_W);

  // Back buffer is the one not selected for scanout.
  assign w_wr_en0 = write_en & w_wr_in_range &  r_buf_sel;
  assign w_wr_en1 = write_en & w_wr_in_range & ~r_buf_sel;

  // Rendering handshake and buffer swap sequencing.
  // The selection toggles on the edge that leaves SWAP, so a write sampled
  // on that same edge still lands in the outgoing back buffer; draw_ack is
  // registered alongside the toggle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_INIT;
      r_draw_start  <= 1'b0;
      r_draw_ack    <= 1'b0;
      r_buf_sel     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_draw_start <= 1'b0;
      r_draw_ack   <= 1'b0;
      case (r_state)
        ST_INIT: begin
          r_draw_start <= 1'b1;
          r_state      <= ST_WAIT_FRAME;
        end
        ST_WAIT_FRAME: begin
          if (frame_done) begin
            r_state <= SYNC_SWAP ? ST_WAIT_VBLANK : ST_SWAP;
          end
        end
        ST_WAIT_VBLANK: begin
          if (vblank_start) begin
            r_state <= ST_SWAP;
          end
        end
        ST_SWAP: begin
          r_buf_sel     <= ~r_buf_sel;
          r_frame_count <= r_frame_count + 8'd1;
          r_draw_ack    <= 1'b1;
          r_state       <= ST_WAIT_FRAME;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  // Back-buffer write port; RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en0) begin
      r_mem0[write_addr] <= write_data;
    end
    if (w_wr_en1) begin
      r_mem1[write_addr] <= write_data;
    end
  end

  // Registered front-buffer read; out-of-range addresses read as zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_read_data <= '0;
    end else if (!w_rd_in_range) begin
      r_read_data <= '0;
    end else if (r_buf_sel) begin
      r_read_data <= r_mem1[read_addr];
    end else begin
      r_read_data <= r_mem0[read_addr];
    end
  end

  assign read_data     = r_read_data;
  assign draw_start    = r_draw_start;
  assign draw_ack      = r_draw_ack;
  assign buffer_select = r_buf_sel;
  assign frame_count   = r_frame_count;

endmodule
